// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the radix-4 FFT butterfly datapath.
// Helpers work on the widest supported configuration; callers cast results to their own width.
package fft_pkg;

    localparam int unsigned MAX_HALF  = 32;
    localparam int unsigned PART_W    = MAX_HALF + 1;
    localparam int unsigned PK_W      = 2 * MAX_HALF + 2;
    localparam int unsigned ACC_W     = 2 * MAX_HALF + 5;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_HALF  = DEF_WIDTH / 2;

    typedef struct packed {
        logic signed [DEF_HALF-1:0] re;
        logic signed [DEF_HALF-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [DEF_HALF:0] re;
        logic signed [DEF_HALF:0] im;
    } twid_t;

    function automatic int unsigned half_of(input int unsigned width);
        return width / 2;
    endfunction

    // Upper half of a packed {re, im} word whose halves are 'bits' wide, sign-extended.
    function automatic logic signed [PART_W-1:0] re_of(input logic [PK_W-1:0] v,
                                                       input int unsigned bits);
        logic signed [PK_W-1:0] t;
        t = v << (PK_W - 2 * bits);
        return PART_W'(t >>> (PK_W - bits));
    endfunction

    function automatic logic signed [PART_W-1:0] im_of(input logic [PK_W-1:0] v,
                                                       input int unsigned bits);
        logic signed [PK_W-1:0] t;
        t = v << (PK_W - bits);
        return PART_W'(t >>> (PK_W - bits));
    endfunction

    // Round half toward +inf, then arithmetic shift.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v,
                                                            input int unsigned shift);
        logic signed [ACC_W-1:0] bias;
        bias = ACC_W'(1) << (shift - 1);
        return (v + bias) >>> shift;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_hi(input int unsigned out_bits);
        return (ACC_W'(1) << (out_bits - 1)) - ACC_W'(1);
    endfunction

    function automatic logic signed [MAX_HALF-1:0] round_sat(input logic signed [ACC_W-1:0] v,
                                                             input int unsigned shift,
                                                             input int unsigned out_bits);
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        r  = round_shift(v, shift);
        hi = sat_hi(out_bits);
        lo = ~hi;
        if (r > hi) begin
            return MAX_HALF'(hi);
        end else if (r < lo) begin
            return MAX_HALF'(lo);
        end
        return MAX_HALF'(r);
    endfunction

    function automatic logic clips(input logic signed [ACC_W-1:0] v,
                                   input int unsigned shift,
                                   input int unsigned out_bits);
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] hi;
        r  = round_shift(v, shift);
        hi = sat_hi(out_bits);
        return (r > hi) || (r < ~hi);
    endfunction

endpackage

// File: rtl/butterfly_4_pipe_if.sv
// Handshake and payload bundle for the pipelined radix-4 butterfly.
interface butterfly_4_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned TW_WIDTH = WIDTH + 2;

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a, b, c, d;
    logic [TW_WIDTH-1:0] w0, w1, w2, w3;
    logic                inverse;
    logic                scale_en;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out0, out1, out2, out3;
    logic                ovf_flag;
    logic                ovf_clr;

    modport master (
        output in_valid, a, b, c, d, w0, w1, w2, w3, inverse, scale_en, out_ready, ovf_clr,
        input  in_ready, out_valid, out0, out1, out2, out3, ovf_flag
    );

    modport slave (
        input  in_valid, a, b, c, d, w0, w1, w2, w3, inverse, scale_en, out_ready, ovf_clr,
        output in_ready, out_valid, out0, out1, out2, out3, ovf_flag
    );
endinterface

// File: rtl/cmul_full.sv
// Registered full-precision complex multiply: sample (HALF bits) times twiddle (HALF+1 bits).
module cmul_full #(
    parameter int unsigned HALF = 16
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic signed [HALF-1:0]  xr_i,
    input  logic signed [HALF-1:0]  xi_i,
    input  logic signed [HALF:0]    wr_i,
    input  logic signed [HALF:0]    wi_i,
    output logic signed [2*HALF+1:0] pr_o,
    output logic signed [2*HALF+1:0] pi_o
);
    localparam int unsigned P_W = 2 * HALF + 2;

    logic signed [P_W-1:0] pr_d, pi_d, pr_q, pi_q;

    always_comb begin
        pr_d = P_W'(xr_i) * P_W'(wr_i) - P_W'(xi_i) * P_W'(wi_i);
        pi_d = P_W'(xi_i) * P_W'(wr_i) + P_W'(xr_i) * P_W'(wi_i);
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            pr_q <= pr_d;
            pi_q <= pi_d;
        end
    end

    assign pr_o = pr_q;
    assign pi_o = pi_q;
endmodule

// File: rtl/butterfly_4_pipe.sv
// Three-stage radix-4 DIT butterfly: input register, complex products, combine/round/saturate.
module butterfly_4_pipe
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    butterfly_4_pipe_if.slave bus
);
    localparam int unsigned HALF     = half_of(WIDTH);
    localparam int unsigned TW_WIDTH = WIDTH + 2;
    localparam int unsigned P_W      = 2 * HALF + 2;
    localparam int unsigned C_W      = 2 * HALF + 4;

    logic                  en_c;
    logic                  s1_valid_q, s2_valid_q, out_valid_q;
    logic                  s1_inv_q, s1_scl_q, s2_inv_q, s2_scl_q;
    logic [WIDTH-1:0]      x_q [4];
    logic [TW_WIDTH-1:0]   w_q [4];
    logic signed [HALF-1:0] xr_c [4];
    logic signed [HALF-1:0] xi_c [4];
    logic signed [HALF:0]   wr_c [4];
    logic signed [HALF:0]   wi_c [4];
    logic signed [P_W-1:0]  tr_c [4];
    logic signed [P_W-1:0]  ti_c [4];
    logic signed [C_W-1:0]  er_c [4];
    logic signed [C_W-1:0]  ei_c [4];
    logic signed [C_W-1:0]  cr_c [4];
    logic signed [C_W-1:0]  ci_c [4];
    int unsigned            shift_c;
    logic [WIDTH-1:0]      out_d [4];
    logic [WIDTH-1:0]      out_q [4];
    logic                  clip_c, ovf_d, ovf_q;

    // Whole pipeline moves in lockstep; bubbles are kept.
    assign en_c         = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en_c;

    always_ff @(posedge clk) begin
        if (en_c) begin
            x_q[0]   <= bus.a;
            x_q[1]   <= bus.b;
            x_q[2]   <= bus.c;
            x_q[3]   <= bus.d;
            w_q[0]   <= bus.w0;
            w_q[1]   <= bus.w1;
            w_q[2]   <= bus.w2;
            w_q[3]   <= bus.w3;
            s1_inv_q <= bus.inverse;
            s1_scl_q <= bus.scale_en;
            s2_inv_q <= s1_inv_q;
            s2_scl_q <= s1_scl_q;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            xr_c[k] = HALF'(re_of(PK_W'(x_q[k]), HALF));
            xi_c[k] = HALF'(im_of(PK_W'(x_q[k]), HALF));
            wr_c[k] = (HALF + 1)'(re_of(PK_W'(w_q[k]), HALF + 1));
            wi_c[k] = (HALF + 1)'(im_of(PK_W'(w_q[k]), HALF + 1));
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_cmul
        cmul_full #(.HALF(HALF)) u_cmul (
            .clk  (clk),
            .en_i (en_c),
            .xr_i (xr_c[k]),
            .xi_i (xi_c[k]),
            .wr_i (wr_c[k]),
            .wi_i (wi_c[k]),
            .pr_o (tr_c[k]),
            .pi_o (ti_c[k])
        );
    end

    // Combine with two guard bits; -j*t = (ti, -tr), +j*t = (-ti, tr).
    always_comb begin
        clip_c  = 1'b0;
        shift_c = HALF - 1 + (s2_scl_q ? 32'd2 : 32'd0);
        for (int k = 0; k < 4; k++) begin
            er_c[k] = C_W'(tr_c[k]);
            ei_c[k] = C_W'(ti_c[k]);
        end
        cr_c[0] = er_c[0] + er_c[1] + er_c[2] + er_c[3];
        ci_c[0] = ei_c[0] + ei_c[1] + ei_c[2] + ei_c[3];
        cr_c[2] = er_c[0] - er_c[1] + er_c[2] - er_c[3];
        ci_c[2] = ei_c[0] - ei_c[1] + ei_c[2] - ei_c[3];
        cr_c[1] = er_c[0] + ei_c[1] - er_c[2] - ei_c[3];
        ci_c[1] = ei_c[0] - er_c[1] - ei_c[2] + er_c[3];
        cr_c[3] = er_c[0] - ei_c[1] - er_c[2] + ei_c[3];
        ci_c[3] = ei_c[0] + er_c[1] - ei_c[2] - er_c[3];
        if (s2_inv_q) begin
            cr_c[1] = er_c[0] - ei_c[1] - er_c[2] + ei_c[3];
            ci_c[1] = ei_c[0] + er_c[1] - ei_c[2] - er_c[3];
            cr_c[3] = er_c[0] + ei_c[1] - er_c[2] - ei_c[3];
            ci_c[3] = ei_c[0] - er_c[1] - ei_c[2] + er_c[3];
        end
        for (int k = 0; k < 4; k++) begin
            out_d[k] = {HALF'(round_sat(ACC_W'(cr_c[k]), shift_c, HALF)),
                        HALF'(round_sat(ACC_W'(ci_c[k]), shift_c, HALF))};
            clip_c   = clip_c | clips(ACC_W'(cr_c[k]), shift_c, HALF)
                              | clips(ACC_W'(ci_c[k]), shift_c, HALF);
        end
    end

    // Sticky overflow: a clipped vector being registered beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (en_c && s2_valid_q && clip_c) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            if (en_c) begin
                s1_valid_q  <= bus.in_valid;
                s2_valid_q  <= s1_valid_q;
                out_valid_q <= s2_valid_q;
                for (int k = 0; k < 4; k++) begin
                    out_q[k] <= out_d[k];
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
    assign bus.ovf_flag  = ovf_q;
endmodule

// File: tb/tb_butterfly_4_pipe.sv
// Directed, table-driven bench for butterfly_4_pipe at WIDTH=32 (1.0 twiddle = 32768).
module tb_butterfly_4_pipe;
    import fft_pkg::*;

    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    butterfly_4_pipe_if #(.WIDTH(W)) bus();
    butterfly_4_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [3:0][31:0] x;
        logic [3:0][33:0] w;
        logic             inv;
        logic             scl;
        logic [3:0][31:0] e;
        logic             eovf;
    } vec_t;

    vec_t tbl[$];
    vec_t expq[$];
    int   sq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] cx(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    function automatic logic [33:0] tw(input int re, input int im);
        return {17'(re), 17'(im)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic [33:0] w0, input logic [33:0] w1,
                       input logic [33:0] w2, input logic [33:0] w3, input logic inv,
                       input logic scl, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3, input logic eovf);
        vec_t v;
        v.x    = {d, c, b, a};
        v.w    = {w3, w2, w1, w0};
        v.inv  = inv;
        v.scl  = scl;
        v.e    = {e3, e2, e1, e0};
        v.eovf = eovf;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.a        = v.x[0];
        bus.b        = v.x[1];
        bus.c        = v.x[2];
        bus.d        = v.x[3];
        bus.w0       = v.w[0];
        bus.w1       = v.w[1];
        bus.w2       = v.w[2];
        bus.w3       = v.w[3];
        bus.inverse  = v.inv;
        bus.scale_en = v.scl;
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, ".out0"}, 64'(bus.out0), 64'(v.e[0]));
        chk({tag, ".out1"}, 64'(bus.out1), 64'(v.e[1]));
        chk({tag, ".out2"}, 64'(bus.out2), 64'(v.e[2]));
        chk({tag, ".out3"}, 64'(bus.out3), 64'(v.e[3]));
    endtask

    // Single vector into an empty pipe: latency, results and overflow flag.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        drive(v);
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(3));
        chk_out(tag, v);
        chk({tag, ".ovf"}, 64'(bus.ovf_flag), 64'(v.eovf));
    endtask

    // Streams tbl[sq[*]] back-to-back, stalling out_ready for 5 cycles from stall_at.
    task automatic stream(input int stall_at, input string tag);
        int   sent;
        int   got;
        int   cyc;
        logic acc;
        vec_t ev;
        sent = 0;
        got  = 0;
        cyc  = 0;
        expq.delete();
        while (got < sq.size() && cyc < 200) begin
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
            #1;
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk({tag, ".spurious"}, 64'(bus.out_valid), 64'(0));
                end else if (bus.out_ready) begin
                    ev = expq.pop_front();
                    chk_out($sformatf("%s.r%0d", tag, got), ev);
                    got++;
                end else begin
                    chk({tag, ".hold"}, 64'(bus.out0), 64'(expq[0].e[0]));
                    chk({tag, ".stall_in_ready"}, 64'(bus.in_ready), 64'(0));
                end
            end
            bus.in_valid = (sent < sq.size());
            if (bus.in_valid) drive(tbl[sq[sent]]);
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                expq.push_back(tbl[sq[sent]]);
                sent++;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, ".count"}, 64'(got), 64'(sq.size()));
        for (int i = 0; i < 4; i++) tick();
        chk({tag, ".drained"}, 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] z;
        logic [33:0] one;
        logic [33:0] zw;
        z   = cx(0, 0);
        zw  = tw(0, 0);
        one = tw(32768, 0);
        add(cx(1000,0), cx(1000,0), cx(1000,0), cx(1000,0), one, one, one, one, 0, 0,
            cx(4000,0), z, z, z, 0);
        add(cx(1000,0), cx(1000,0), cx(1000,0), cx(1000,0), one, one, one, one, 0, 1,
            cx(1000,0), z, z, z, 0);
        add(cx(30000,0), cx(30000,0), cx(30000,0), cx(30000,0), one, one, one, one, 0, 0,
            cx(32767,0), z, z, z, 1);
        add(z, cx(0,1000), z, z, one, one, one, one, 0, 0,
            cx(0,1000), cx(1000,0), cx(0,-1000), cx(-1000,0), 0);
        add(z, cx(0,1000), z, z, one, one, one, one, 1, 0,
            cx(0,1000), cx(-1000,0), cx(0,-1000), cx(1000,0), 0);
        add(cx(3,0), z, z, z, tw(16384,0), zw, zw, zw, 0, 0,
            cx(2,0), cx(2,0), cx(2,0), cx(2,0), 0);
        add(cx(-3,0), z, z, z, tw(16384,0), zw, zw, zw, 0, 0,
            cx(-1,0), cx(-1,0), cx(-1,0), cx(-1,0), 0);
        add(cx(100,-200), z, z, z, tw(-32768,0), zw, zw, zw, 0, 0,
            cx(-100,200), cx(-100,200), cx(-100,200), cx(-100,200), 0);
        add(cx(100,50), z, z, z, tw(0,32768), zw, zw, zw, 0, 0,
            cx(-50,100), cx(-50,100), cx(-50,100), cx(-50,100), 0);
        add(cx(-30000,0), cx(-30000,0), cx(-30000,0), cx(-30000,0), one, one, one, one, 0, 0,
            cx(-32768,0), z, z, z, 1);
        add(cx(400,0), cx(0,800), cx(-1200,0), cx(0,-1600), one, one, one, one, 0, 1,
            cx(-200,-200), cx(1000,0), cx(-200,200), cx(-200,0), 0);
        add(cx(2,0), z, z, z, one, zw, zw, zw, 0, 1,
            cx(1,0), cx(1,0), cx(1,0), cx(1,0), 0);
        add(cx(-2,0), z, z, z, one, zw, zw, zw, 0, 1,
            z, z, z, z, 0);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
        drive(tbl[0]);
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst.ovf", 64'(bus.ovf_flag), 64'(0));
        chk("rst.out0", 64'(bus.out0), 64'(0));
        chk("rst.out3", 64'(bus.out3), 64'(0));
        chk("rst.in_ready", 64'(bus.in_ready), 64'(1));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
            bus.ovf_clr = 1'b1;
            tick();
            bus.ovf_clr = 1'b0;
        end

        // Sticky flag holds until cleared; a coincident set beats the clear.
        run_vec(tbl[2], "sticky");
        for (int i = 0; i < 4; i++) tick();
        chk("sticky.hold", 64'(bus.ovf_flag), 64'(1));
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("sticky.cleared", 64'(bus.ovf_flag), 64'(0));
        tick();
        chk("sticky.stays_clear", 64'(bus.ovf_flag), 64'(0));
        bus.ovf_clr = 1'b1;
        run_vec(tbl[2], "setwins");
        bus.ovf_clr = 1'b0;
        tick();
        chk("setwins.hold", 64'(bus.ovf_flag), 64'(1));
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;

        sq = '{3, 4, 3, 4};
        stream(1000, "alt");

        sq = '{0, 1, 3, 4, 5, 6, 7, 8};
        stream(4, "stall");

        // Reset with three vectors in flight, the oldest already at the output.
        drive(tbl[2]);
        bus.in_valid = 1'b1;
        tick();
        drive(tbl[0]);
        tick();
        drive(tbl[3]);
        tick();
        chk("midrst.pre_valid", 64'(bus.out_valid), 64'(1));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        chk("midrst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst.ovf", 64'(bus.ovf_flag), 64'(0));
        chk("midrst.out0", 64'(bus.out0), 64'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("midrst.stale%0d", i), 64'(bus.out_valid), 64'(0));
        end
        run_vec(tbl[10], "post_rst");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
